// File: rtl/watch_set_ctrl_pkg.sv
// Shared watch encodings and counter terminal counts.
package watch_pkg;

    typedef enum logic [1:0] {
        NORMAL   = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        SET_SEC  = 2'd3
    } mode_e;

    localparam int unsigned SEC_MAX  = 59;
    localparam int unsigned MIN_MAX  = 59;
    localparam int unsigned HOUR_MAX = 23;
    localparam int unsigned VAL_W    = 8;

    // Mode button order: NORMAL -> SET_HOUR -> SET_MIN -> SET_SEC -> NORMAL.
    function automatic mode_e next_mode(input mode_e m);
        return mode_e'(2'(m + 2'd1));
    endfunction

endpackage

// File: rtl/watch_set_ctrl_inc_repeat.sv
// Increment button edge detector with hold-to-repeat.
module inc_repeat #(
    parameter int unsigned REPEAT_DLY = 500,
    parameter int unsigned REPEAT_PER = 100
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic lvl,
    output logic pulse_c
);

    localparam int unsigned CNT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    logic             lvl_q;
    logic             armed;
    logic             in_rpt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] target_c;
    logic             rise_c;
    logic             rpt_c;

    // A level held across a clear keeps lvl_q high, so it never looks like a fresh edge.
    always_comb begin
        rise_c   = lvl && !lvl_q && !clr;
        target_c = in_rpt ? CNT_W'(REPEAT_PER) : CNT_W'(REPEAT_DLY);
        rpt_c    = armed && lvl && !clr && (cnt == target_c);
        pulse_c  = rise_c || rpt_c;
    end

    // cnt holds cycles since the last issued pulse while the button stays armed.
    always_ff @(posedge clock) begin
        if (reset) begin
            lvl_q  <= 1'b0;
            armed  <= 1'b0;
            in_rpt <= 1'b0;
            cnt    <= '0;
        end else begin
            lvl_q <= lvl;
            if (clr || !lvl) begin
                armed  <= 1'b0;
                in_rpt <= 1'b0;
                cnt    <= '0;
            end else if (rise_c) begin
                armed  <= 1'b1;
                in_rpt <= 1'b0;
                cnt    <= CNT_W'(1);
            end else if (rpt_c) begin
                in_rpt <= 1'b1;
                cnt    <= CNT_W'(1);
            end else if (armed && (cnt != CNT_W'(CNT_MAX))) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/watch_set_ctrl.sv
// Watch time-set controller: mode FSM, carry generation, set timeout and blink.
module watch_set_ctrl
    import watch_pkg::*;
#(
    parameter int unsigned SEC_MAX    = watch_pkg::SEC_MAX,
    parameter int unsigned MIN_MAX    = watch_pkg::MIN_MAX,
    parameter int unsigned REPEAT_DLY = 500,
    parameter int unsigned REPEAT_PER = 100,
    parameter int unsigned TIMEOUT    = 30
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       mode_btn,
    input  logic       inc_lvl,
    input  logic [7:0] sec_val,
    input  logic [7:0] min_val,
    input  logic [7:0] hour_val,
    output logic       sec_pulse,
    output logic       min_pulse,
    output logic       hour_pulse,
    output logic [1:0] mode,
    output logic       blink
);

    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

    mode_e             state;
    mode_e             state_d;
    logic [IDLE_W-1:0] idle;
    logic [IDLE_W-1:0] idle_d;
    logic              blink_d;
    logic              sec_d;
    logic              min_d;
    logic              hour_d;
    logic              clr_c;
    logic              inc_c;
    logic              unused_c;

    // Hours wrap in the counter itself; the value is not needed here.
    assign unused_c = ^hour_val;

    inc_repeat #(
        .REPEAT_DLY(REPEAT_DLY),
        .REPEAT_PER(REPEAT_PER)
    ) u_inc (
        .clock  (clock),
        .reset  (reset),
        .clr    (clr_c),
        .lvl    (inc_lvl),
        .pulse_c(inc_c)
    );

    // Next state: mode button beats timeout; any change (or NORMAL) clears the repeater.
    always_comb begin
        state_d = state;
        if (mode_btn) begin
            state_d = next_mode(state);
        end else if ((state != NORMAL) && (idle == IDLE_W'(TIMEOUT))) begin
            state_d = NORMAL;
        end
        clr_c = (state == NORMAL) || (state_d != state);
    end

    // Pulse routing, idle counting and blink update.
    always_comb begin
        sec_d   = 1'b0;
        min_d   = 1'b0;
        hour_d  = 1'b0;
        idle_d  = idle;
        blink_d = blink;

        case (state)
            NORMAL: begin
                if (tick) begin
                    sec_d  = 1'b1;
                    min_d  = (sec_val == 8'(SEC_MAX));
                    hour_d = min_d && (min_val == 8'(MIN_MAX));
                end
            end
            SET_HOUR: hour_d = inc_c;
            SET_MIN:  min_d  = inc_c;
            SET_SEC:  sec_d  = inc_c;
        endcase

        if ((state == NORMAL) || (state_d != state) || inc_c) begin
            idle_d = '0;
        end else if (tick && (idle != IDLE_W'(TIMEOUT))) begin
            idle_d = idle + IDLE_W'(1);
        end

        if ((state_d == NORMAL) || (state_d != state) || inc_c) begin
            blink_d = 1'b1;
        end else if (tick) begin
            blink_d = !blink;
        end
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= NORMAL;
            idle       <= '0;
            blink      <= 1'b1;
            sec_pulse  <= 1'b0;
            min_pulse  <= 1'b0;
            hour_pulse <= 1'b0;
        end else begin
            state      <= state_d;
            idle       <= idle_d;
            blink      <= blink_d;
            sec_pulse  <= sec_d;
            min_pulse  <= min_d;
            hour_pulse <= hour_d;
        end
    end

    assign mode = state;

endmodule

// File: doc/watch_set_ctrl.md
WATCH_SET_CTRL -- requirements
Module: watch_set_ctrl

Interface
REQ-001 Parameter SEC_MAX, 59, seconds terminal count.
REQ-002 Parameter MIN_MAX, 59, minutes terminal count.
REQ-003 Parameter REPEAT_DLY, 500, clock cycles inc_lvl must stay high before the first auto-repeat pulse.
REQ-004 Parameter REPEAT_PER, 100, clock cycles between auto-repeat pulses.
REQ-005 Parameter TIMEOUT, 30, idle ticks in a set state before the block returns to NORMAL.
REQ-006 Port clock, input, 1, single clock; all logic SHALL be on its rising edge.
REQ-007 Port reset, input, 1, synchronous, active-high reset.
REQ-008 Port tick, input, 1, one-cycle 1 Hz strobe.
REQ-009 Port mode_btn, input, 1, one-cycle debounced mode-press strobe.
REQ-010 Port inc_lvl, input, 1, debounced increment-button level.
REQ-011 Ports sec_val, min_val, hour_val, input, 8 each, current counter values.
REQ-012 Ports sec_pulse, min_pulse, hour_pulse, output, 1 each, increment strobes to the seconds, minutes and hours counters.
REQ-013 Port mode, output, 2, current state encoding.
REQ-014 Port blink, output, 1, display enable for the field being set.

Function
REQ-015 States SHALL be NORMAL=0, SET_HOUR=1, SET_MIN=2, SET_SEC=3.
REQ-016 A mode_btn strobe SHALL advance the state NORMAL->SET_HOUR->SET_MIN->SET_SEC->NORMAL, one step per strobe.
REQ-017 NORMAL, tick: sec_pulse SHALL assert for exactly one cycle, one cycle after tick.
REQ-018 NORMAL, tick with sec_val==SEC_MAX: min_pulse SHALL assert in the same cycle as sec_pulse.
REQ-019 NORMAL, tick with sec_val==SEC_MAX and min_val==MIN_MAX: hour_pulse SHALL also assert in that cycle.
REQ-020 Set states: tick SHALL NOT produce any counter pulse, so timekeeping is frozen.
REQ-021 Set states, rising edge of inc_lvl: exactly one pulse SHALL go to the selected field only, one cycle later, with no carry.
REQ-022 Set states, inc_lvl held high: a further pulse SHALL occur REPEAT_DLY cycles after the edge, then one every REPEAT_PER cycles until inc_lvl falls.
REQ-023 At most one of the three pulse outputs SHALL be high in any cycle while in a set state.
REQ-024 mode_btn and an inc_lvl rising edge in the same cycle: mode_btn SHALL win, no pulse SHALL be issued, and the repeat counter SHALL clear.
REQ-025 After any state change, increments SHALL require a fresh inc_lvl rising edge; a level held across the change SHALL be ignored.
REQ-026 Timeout: the idle counter SHALL count ticks in a set state and clear on mode_btn or any inc pulse.
REQ-027 When the idle counter reaches TIMEOUT, the next state SHALL be NORMAL.
REQ-028 blink SHALL be 1 in NORMAL.
REQ-029 blink SHALL be set to 1 on entry to each set state and on each inc pulse, and SHALL toggle on each tick otherwise.
REQ-030 All outputs SHALL be registered.
REQ-031 Repeat and idle counters SHALL saturate, never wrap.

Reset
REQ-032 While reset is high at a clock edge: mode=NORMAL, all pulses=0, blink=1, repeat and idle counters=0, inc edge history=0.
REQ-033 Reset asserted mid-repeat or mid-set SHALL abort the operation with no pulse in the following cycle.
REQ-034 The first cycle after reset SHALL honour tick and mode_btn normally.

Structure
REQ-035 Package watch_pkg SHALL hold the state encodings and the SEC_MAX/MIN_MAX/HOUR_MAX constants shared with the counter instances.
REQ-036 Sub-module inc_repeat SHALL implement edge detection and auto-repeat.
REQ-037 inc_repeat SHALL have inputs clock, reset, clr and lvl, and output a one-cycle strobe.
REQ-038 The state machine, carry logic, timeout and blink logic SHALL live in watch_set_ctrl.

Verification
REQ-039 NORMAL, sec_val=59, min_val=59, tick -> sec_pulse, min_pulse and hour_pulse all high for one cycle, one cycle later.
REQ-040 NORMAL, sec_val=30, tick -> only sec_pulse high.
REQ-041 Three mode_btn strobes, then inc_lvl high for 720 cycles -> state SET_SEC; sec_pulse at +1, +501, +601 and +701 cycles; no other pulses.
REQ-042 SET_MIN, mode_btn and inc_lvl rise in the same cycle -> state SET_SEC; no pulse until inc_lvl falls and rises again.
REQ-043 SET_HOUR, 30 ticks with no activity -> state NORMAL; the next tick yields sec_pulse.
REQ-044 reset asserted 250 cycles into an inc_lvl hold -> mode=NORMAL, blink=1, no pulse after release while inc_lvl stays high.
